level_judge: RTL and testbench

LEVEL_JUDGE -- requirements
Module: level_judge

---
 rtl/bnw_pkg.sv | 19 +
 rtl/sat_counter.sv | 32 +++
 rtl/level_judge.sv | 106 ++++++++++
 tb/tb_level_judge.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bnw_pkg.sv
// Shared definitions for the beat-and-wave level logic.
//   state_t        : level FSM encoding (IDLE=0, PLAY=1, PASS=2, FAIL=3)
//   PASS_HITS_DEF  : default minimum hit count for a level pass
//   MAX_MISS_DEF   : default miss count that ends a level immediately
//   MISS_W         : width of the miss counter
package bnw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int PASS_HITS_DEF = 16;
  localparam int MAX_MISS_DEF  = 3;
  localparam int MISS_W        = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear to 0 (wins over inc)
//   inc        : add one, holding at all-ones
//   count      : registered count
//   next_val   : value count takes on the next edge, so callers can judge
//                on the post-update count in the same cycle
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] next_val
);

  always_comb begin
    next_val = count;
    if (clr)
      next_val = '0;
    else if (inc && (count != '1))
      next_val = count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= next_val;
  end

endmodule

// File: rtl/level_judge.sv
// Level pass/fail judge.
// Counts hits and misses while a level is playing, fails the level as soon
// as the miss limit is reached, and on song_done passes it if enough notes
// were hit.
//   clk, rst    : clock, asynchronous active-high reset
//   restart     : synchronous return to idle with counters cleared
//   start       : begin a level (accepted only in idle)
//   note_valid  : one note's hit window closed; note_hit says hit or miss
//   song_done   : last note window closed
//   endgame     : one-cycle pass pulse
//   fail        : one-cycle fail pulse
//   hit_cnt     : hits in the current/last level
//   miss_cnt    : misses in the current/last level
//   busy        : level in progress
module level_judge #(
  parameter int PASS_HITS = bnw_pkg::PASS_HITS_DEF,
  parameter int MAX_MISS  = bnw_pkg::MAX_MISS_DEF,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             start,
  input  logic             note_valid,
  input  logic             note_hit,
  input  logic             song_done,
  output logic             endgame,
  output logic             fail,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [3:0]       miss_cnt,
  output logic             busy
);
  import bnw_pkg::*;

  localparam logic [CNT_W-1:0]  PASS_THR = CNT_W'(PASS_HITS);
  localparam logic [MISS_W-1:0] MISS_THR = MISS_W'(MAX_MISS);

  state_t state;

  logic              in_play, clr, hit_inc, miss_inc, miss_trip;
  logic [CNT_W-1:0]  hit_next;
  logic [MISS_W-1:0] miss_next;

  assign in_play  = (state == ST_PLAY);
  // Counters clear on an accepted start or on restart.
  assign clr      = restart | ((state == ST_IDLE) & start);
  assign hit_inc  = in_play & note_valid &  note_hit;
  assign miss_inc = in_play & note_valid & ~note_hit;
  // Only the edge on which the count steps onto the limit trips the fail.
  assign miss_trip = miss_inc & (miss_next == MISS_THR);
  assign busy     = in_play;

  sat_counter #(.W(CNT_W)) u_hit (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc      (hit_inc),
    .count    (hit_cnt),
    .next_val (hit_next)
  );

  sat_counter #(.W(MISS_W)) u_miss (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc      (miss_inc),
    .count    (miss_cnt),
    .next_val (miss_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      endgame <= 1'b0;
      fail    <= 1'b0;
    end else if (restart) begin
      state   <= ST_IDLE;
      endgame <= 1'b0;
      fail    <= 1'b0;
    end else begin
      endgame <= 1'b0;
      fail    <= 1'b0;
      case (state)
        ST_IDLE: if (start) state <= ST_PLAY;
        ST_PLAY: begin
          // Miss limit beats song_done; the pass test uses the count
          // including any note closing on this same edge.
          if (miss_trip) begin
            state <= ST_FAIL;
            fail  <= 1'b1;
          end else if (song_done) begin
            if (hit_next >= PASS_THR) begin
              state   <= ST_PASS;
              endgame <= 1'b1;
            end else begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_judge.sv
module tb_level_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0, start = 1'b0;
  logic       note_valid = 1'b0, note_hit = 1'b0, song_done = 1'b0;
  logic       endgame, fail, busy;
  logic [7:0] hit_cnt;
  logic [3:0] miss_cnt;

  int checks = 0;
  int failures = 0;

  level_judge dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .start      (start),
    .note_valid (note_valid),
    .note_hit   (note_hit),
    .song_done  (song_done),
    .endgame    (endgame),
    .fail       (fail),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic notes(input int n, input logic h);
    note_valid = 1'b1; note_hit = h;
    repeat (n) tick();
    note_valid = 1'b0; note_hit = 1'b0;
  endtask

  task automatic outs(input string tag, input int eg, input int fl, input int hc,
                      input int mc, input int bz);
    chk({tag, ".endgame"}, int'(endgame), eg);
    chk({tag, ".fail"},    int'(fail),    fl);
    chk({tag, ".hit_cnt"}, int'(hit_cnt), hc);
    chk({tag, ".miss_cnt"},int'(miss_cnt),mc);
    chk({tag, ".busy"},    int'(busy),    bz);
  endtask

  initial begin
    #2;
    outs("reset", 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    outs("idle", 0, 0, 0, 0, 0);

    // Pass with exactly 16 hits
    do_start();
    outs("a_start", 0, 0, 0, 0, 1);
    notes(16, 1'b1);
    chk("a_hits", int'(hit_cnt), 16);
    song_done = 1'b1; tick(); song_done = 1'b0;
    outs("a_pass", 1, 0, 16, 0, 0);
    tick();
    outs("a_after", 0, 0, 16, 0, 0);

    // 15 hits is one short
    do_start();
    outs("b_start", 0, 0, 0, 0, 1);
    notes(15, 1'b1);
    song_done = 1'b1; tick(); song_done = 1'b0;
    outs("b_fail", 0, 1, 15, 0, 0);
    tick();
    outs("b_after", 0, 0, 15, 0, 0);

    // Third miss ends the level; song_done afterwards is ignored
    do_start();
    notes(1, 1'b1); notes(1, 1'b0);
    notes(1, 1'b1); notes(1, 1'b0);
    outs("c_mid", 0, 0, 2, 2, 1);
    notes(1, 1'b1); notes(1, 1'b0);
    outs("c_fail", 0, 1, 3, 3, 0);
    tick();
    song_done = 1'b1; note_valid = 1'b1; note_hit = 1'b1; tick();
    song_done = 1'b0; note_valid = 1'b0; note_hit = 1'b0;
    outs("c_ignored", 0, 0, 3, 3, 0);

    // 16th hit lands with song_done; stray start during play is ignored
    do_start();
    outs("d_start", 0, 0, 0, 0, 1);
    notes(5, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    outs("d_restart_ign", 0, 0, 5, 0, 1);
    notes(10, 1'b1);
    note_valid = 1'b1; note_hit = 1'b1; song_done = 1'b1; tick();
    note_valid = 1'b0; note_hit = 1'b0; song_done = 1'b0;
    outs("d_pass", 1, 0, 16, 0, 0);
    tick();
    outs("d_after", 0, 0, 16, 0, 0);

    // Async reset mid-level, with no pulse, then a normal level
    do_start();
    notes(9, 1'b1);
    chk("e_hits", int'(hit_cnt), 9);
    #2 rst = 1'b1;
    #1 outs("e_rst", 0, 0, 0, 0, 0);
    song_done = 1'b1; tick(); song_done = 1'b0;
    outs("e_rst_hold", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    outs("e_released", 0, 0, 0, 0, 0);
    do_start();
    notes(16, 1'b1);
    song_done = 1'b1; tick(); song_done = 1'b0;
    outs("e_pass", 1, 0, 16, 0, 0);
    tick();

    // restart wins over song_done
    do_start();
    notes(16, 1'b1); notes(1, 1'b0);
    song_done = 1'b1; restart = 1'b1; tick();
    song_done = 1'b0; restart = 1'b0;
    outs("f_restart", 0, 0, 0, 0, 0);
    tick();
    outs("f_after", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
